// File: rtl/tdm_demux_4ch.sv
// tdm_demux_4ch -- receive side of a 4:1 slot-multiplexed link.
//   Recovers slot timing from frame_sync, de-interleaves din into four channel
//   registers and presents them together with a one-cycle frame_valid pulse.
// Ports:
//   clk, reset (sync, active-low) | din, frame_sync (line in)
//   y0..y3 (recovered channels), sel (current slot), frame_valid, sync_err, par_err
// Latency: last slot sample to y0..y3/frame_valid is 1 cycle. No backpressure;
//   consumers must take each frame in the frame_valid cycle.
// Build option: define TDM_DEMUX_PARITY_EN to add a fifth parity slot (XOR of
//   channels 0..3); sel then widens to 3 bits and par_err becomes live.

module tdm_demux_4ch #(
   parameter int DATA_W      = 1,
   parameter int SLOT_CYCLES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] din,
   input  logic              frame_sync,
   output logic [DATA_W-1:0] y0,
   output logic [DATA_W-1:0] y1,
   output logic [DATA_W-1:0] y2,
   output logic [DATA_W-1:0] y3,
`ifdef TDM_DEMUX_PARITY_EN
   output logic [2:0]        sel,
`else
   output logic [1:0]        sel,
`endif
   output logic              frame_valid,
   output logic              sync_err,
   output logic              par_err
);

`ifdef TDM_DEMUX_PARITY_EN
   localparam int N     = 5;
   localparam int SEL_W = 3;
`else
   localparam int N     = 4;
   localparam int SEL_W = 2;
`endif
   localparam int              CW         = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam logic [CW-1:0]   CYC_LAST   = CW'(SLOT_CYCLES - 1);
   localparam logic [2:0]      SLOT_LAST  = 3'(N - 1);

   typedef enum logic {HUNT, LOCK} state_t;

   state_t            state_q, state_d;
   logic [2:0]        slot_cnt_q, slot_cnt_d;
   logic [CW-1:0]     cyc_cnt_q, cyc_cnt_d;
   logic [DATA_W-1:0] shadow_q [N];
   logic [DATA_W-1:0] shadow_d [N];
   logic [DATA_W-1:0] y_q [4];
   logic [DATA_W-1:0] y_d [4];
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              frame_valid_q, frame_valid_d;
   logic              sync_err_q, sync_err_d;
`ifdef TDM_DEMUX_PARITY_EN
   logic              par_err_q, par_err_d;
`endif

   // Position of the current cycle within the frame. Normally the counters,
   // but forced to slot 0 / cycle 0 when this cycle starts a (re)locked frame.
   logic              advance;
   logic [2:0]        pos_slot;
   logic [CW-1:0]     pos_cyc;
   logic              frame_end;
   logic              par_ok;

   always_comb begin
      state_d       = state_q;
      slot_cnt_d    = slot_cnt_q;
      cyc_cnt_d     = cyc_cnt_q;
      shadow_d      = shadow_q;
      y_d           = y_q;
      frame_valid_d = 1'b0;
      sync_err_d    = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      par_err_d     = 1'b0;
`endif
      advance       = 1'b0;
      pos_slot      = slot_cnt_q;
      pos_cyc       = cyc_cnt_q;
      frame_end     = 1'b0;
      par_ok        = 1'b1;

      case (state_q)
         HUNT: begin
            if (frame_sync) begin
               state_d  = LOCK;
               advance  = 1'b1;
               pos_slot = 3'd0;
               pos_cyc  = '0;
            end
         end
         LOCK: begin
            advance = 1'b1;
            // A sync exactly on the flywheel wrap is redundant; anywhere else
            // it re-times the frame and the partial frame is dropped.
            if (frame_sync && ((slot_cnt_q != 3'd0) || (cyc_cnt_q != '0))) begin
               sync_err_d = 1'b1;
               pos_slot   = 3'd0;
               pos_cyc    = '0;
            end
         end
         default: state_d = HUNT;
      endcase

      if (advance) begin
         if (pos_cyc == CYC_LAST) begin
            for (int k = 0; k < N; k++) begin
               if (pos_slot == 3'(k)) shadow_d[k] = din;
            end
            cyc_cnt_d = '0;
            if (pos_slot == SLOT_LAST) begin
               slot_cnt_d = 3'd0;
               frame_end  = 1'b1;
            end else begin
               slot_cnt_d = pos_slot + 3'd1;
            end
         end else begin
            cyc_cnt_d  = pos_cyc + CW'(1);
            slot_cnt_d = pos_slot;
         end
      end

`ifdef TDM_DEMUX_PARITY_EN
      par_ok = ((shadow_d[0] ^ shadow_d[1] ^ shadow_d[2] ^ shadow_d[3]) == shadow_d[4]);
`endif

      // shadow_d already holds the sample taken in this final cycle.
      if (frame_end) begin
         if (par_ok) begin
            for (int k = 0; k < 4; k++) y_d[k] = shadow_d[k];
            frame_valid_d = 1'b1;
         end
`ifdef TDM_DEMUX_PARITY_EN
         else begin
            par_err_d = 1'b1;
         end
`endif
      end

      sel_d = slot_cnt_d[SEL_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= HUNT;
         slot_cnt_q    <= 3'd0;
         cyc_cnt_q     <= '0;
         for (int k = 0; k < N; k++) shadow_q[k] <= '0;
         for (int k = 0; k < 4; k++) y_q[k] <= '0;
         sel_q         <= '0;
         frame_valid_q <= 1'b0;
         sync_err_q    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
         par_err_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         slot_cnt_q    <= slot_cnt_d;
         cyc_cnt_q     <= cyc_cnt_d;
         shadow_q      <= shadow_d;
         y_q           <= y_d;
         sel_q         <= sel_d;
         frame_valid_q <= frame_valid_d;
         sync_err_q    <= sync_err_d;
`ifdef TDM_DEMUX_PARITY_EN
         par_err_q     <= par_err_d;
`endif
      end
   end

   assign y0          = y_q[0];
   assign y1          = y_q[1];
   assign y2          = y_q[2];
   assign y3          = y_q[3];
   assign sel         = sel_q;
   assign frame_valid = frame_valid_q;
   assign sync_err    = sync_err_q;
`ifdef TDM_DEMUX_PARITY_EN
   assign par_err     = par_err_q;
`else
   assign par_err     = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Bench for tdm_demux_4ch (default build, DATA_W=1, SLOT_CYCLES=4).
// Reference model tracks a single frame phase (cycles since frame start);
// slot = phase / S, sample on the last cycle of each slot.

module tb_tdm_demux_4ch;

   localparam int W  = 1;
   localparam int S  = 4;
   localparam int N  = 4;
   localparam int FL = N * S;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [W-1:0] din = '0;
   logic         frame_sync = 1'b0;
   logic [W-1:0] y0, y1, y2, y3;
   logic [1:0]   sel;
   logic         frame_valid, sync_err, par_err;

   tdm_demux_4ch #(.DATA_W(W), .SLOT_CYCLES(S)) dut (
      .clk(clk), .reset(reset), .din(din), .frame_sync(frame_sync),
      .y0(y0), .y1(y1), .y2(y2), .y3(y3), .sel(sel),
      .frame_valid(frame_valid), .sync_err(sync_err), .par_err(par_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int fv_cnt = 0;
   int se_cnt = 0;

   // reference model state
   bit           m_locked = 1'b0;
   int           m_ph = 0;
   logic [W-1:0] m_buf [N];
   logic [W-1:0] m_y [4];
   int           m_sel = 0;
   bit           m_fv = 1'b0;
   bit           m_serr = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic step(input logic [W-1:0] d, input bit fs, input bit rst_n);
      bit adv;
      adv = 1'b0;
      din = d;
      frame_sync = fs;
      reset = rst_n;
      m_fv = 1'b0;
      m_serr = 1'b0;
      if (!rst_n) begin
         m_locked = 1'b0;
         m_ph = 0;
         m_sel = 0;
         for (int k = 0; k < N; k++) m_buf[k] = '0;
         for (int k = 0; k < 4; k++) m_y[k] = '0;
      end else begin
         if (!m_locked) begin
            if (fs) begin
               m_locked = 1'b1;
               m_ph = 0;
               adv = 1'b1;
            end
         end else begin
            adv = 1'b1;
            if (fs && m_ph != 0) begin
               m_serr = 1'b1;
               m_ph = 0;
            end
         end
         if (adv) begin
            if (m_ph % S == S - 1) m_buf[m_ph / S] = d;
            if (m_ph == FL - 1) begin
               for (int k = 0; k < 4; k++) m_y[k] = m_buf[k];
               m_fv = 1'b1;
            end
            m_ph = (m_ph + 1) % FL;
            m_sel = m_ph / S;
         end
      end
      @(posedge clk);
      #1;
      if (frame_valid === 1'b1) fv_cnt++;
      if (sync_err === 1'b1) se_cnt++;
      chk("y0", 32'(y0), 32'(m_y[0]));
      chk("y1", 32'(y1), 32'(m_y[1]));
      chk("y2", 32'(y2), 32'(m_y[2]));
      chk("y3", 32'(y3), 32'(m_y[3]));
      chk("sel", 32'(sel), 32'(m_sel));
      chk("frame_valid", 32'(frame_valid), 32'(m_fv));
      chk("sync_err", 32'(sync_err), 32'(m_serr));
      chk("par_err", 32'(par_err), 32'd0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(W'($urandom), 1'b0, 1'b1);
   endtask

   // v[k] is the value of channel k; off-sample cycles carry junk.
   task automatic frame(input logic [3:0] v, input bit fs_first, input int ncyc);
      for (int c = 0; c < ncyc; c++)
         step(((c % S) == S - 1) ? W'(v[c / S]) : W'($urandom), fs_first && (c == 0), 1'b1);
   endtask

   initial begin
      int fv0, se0;

      // reset, then hunt with no sync
      for (int i = 0; i < 3; i++) step(W'($urandom), 1'b0, 1'b0);
      idle(50);
      chk("hunt_no_fv", 32'(fv_cnt), 32'd0);

      // basic frame 1,0,1,1
      fv0 = fv_cnt;
      frame(4'b1101, 1'b1, FL);
      chk("basic_fv", 32'(fv_cnt - fv0), 32'd1);
      chk("basic_y", 32'({y3, y2, y1, y0}), 32'h0000000d);

      // flywheel: three frames without sync
      fv0 = fv_cnt;
      frame(4'b0110, 1'b0, FL);
      chk("fly1_y", 32'({y3, y2, y1, y0}), 32'h00000006);
      frame(4'b1111, 1'b0, FL);
      chk("fly2_y", 32'({y3, y2, y1, y0}), 32'h0000000f);
      frame(4'b1000, 1'b0, FL);
      chk("fly3_y", 32'({y3, y2, y1, y0}), 32'h00000008);
      chk("fly_fv", 32'(fv_cnt - fv0), 32'd3);

      // misplaced sync in slot 2
      fv0 = fv_cnt;
      se0 = se_cnt;
      frame(4'b0101, 1'b1, 9);
      frame(4'b0011, 1'b1, FL);
      chk("missync_fv", 32'(fv_cnt - fv0), 32'd1);
      chk("missync_se", 32'(se_cnt - se0), 32'd1);
      chk("missync_y", 32'({y3, y2, y1, y0}), 32'h00000003);

      // sync on the last cycle of slot 3: that frame is not delivered
      fv0 = fv_cnt;
      se0 = se_cnt;
      frame(4'b1110, 1'b0, FL - 1);
      frame(4'b1001, 1'b1, FL);
      chk("latesync_fv", 32'(fv_cnt - fv0), 32'd1);
      chk("latesync_se", 32'(se_cnt - se0), 32'd1);
      chk("latesync_y", 32'({y3, y2, y1, y0}), 32'h00000009);

      // reset mid-frame, then stay in hunt
      frame(4'b1111, 1'b0, 8);
      step(W'($urandom), 1'b0, 1'b0);
      chk("rst_y", 32'({y3, y2, y1, y0}), 32'd0);
      chk("rst_sel", 32'(sel), 32'd0);
      fv0 = fv_cnt;
      idle(30);
      chk("rst_hunt_fv", 32'(fv_cnt - fv0), 32'd0);

      // randomized traffic with occasional sync and reset
      frame(4'(($urandom)), 1'b1, FL);
      for (int i = 0; i < 1200; i++)
         step(W'($urandom), ($urandom_range(0, 39) == 0), ($urandom_range(0, 299) != 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
